fft_cooley_tukey_stage_sequencer: RTL and testbench
===================================================

Name: fft_cooley_tukey_stage_sequencer

Overview:
- Sequences a folded Cooley-Tukey FFT: one external stage datapath (front crossbar, butterflies, back crossbar) is reused for all log2(SIZE_FFT) stages.
- Accepts a full frame, holds it in an internal buffer, and runs the stages in order 0..N_STAGES-1, driving the stage index that configures the crossbars and twiddles.
- Emits the finished frame downstream.
- Sits between the frame source (deserializer) and the output serializer.

Parameters:
- BIT_WIDTH, 32, data bit width of each real/imaginary word.
- SIZE_FFT, 8, FFT points; power of two, >= 2.
- N_STAGES, $clog2(SIZE_FFT), derived stage count; not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- recv_real  in  BIT_WIDTH x SIZE_FFT  input frame, real parts.
- recv_imaginary  in  BIT_WIDTH x SIZE_FFT  input frame, imaginary parts.
- recv_val  in  1  input frame valid.
- recv_rdy  out  1  sequencer can accept a frame.
- dp_send_real  out  BIT_WIDTH x SIZE_FFT  buffer contents to stage datapath.
- dp_send_imaginary  out  BIT_WIDTH x SIZE_FFT  same, imaginary parts.
- dp_send_val  out  1  operands valid.
- dp_send_rdy  in  1  datapath accepts operands.
- dp_stage  out  max(1,$clog2(N_STAGES))  current stage index.
- dp_recv_real  in  BIT_WIDTH x SIZE_FFT  stage result, real parts.
- dp_recv_imaginary  in  BIT_WIDTH x SIZE_FFT  stage result, imaginary parts.
- dp_recv_val  in  1  result valid.
- dp_recv_rdy  out  1  sequencer accepts result.
- send_real  out  BIT_WIDTH x SIZE_FFT  output frame, real parts.
- send_imaginary  out  BIT_WIDTH x SIZE_FFT  output frame, imaginary parts.
- send_val  out  1  output frame valid.
- send_rdy  in  1  downstream accepts frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Handshake: transfer occurs on a cycle where val && rdy. A val, once raised, holds with stable data until the transfer.
- FSM states: IDLE, ISSUE, WAIT, DRAIN. Outputs decode combinationally from state.
- Reset: state = IDLE, stage counter = 0, buffer cleared to 0. Outputs: recv_rdy = 1, dp_send_val = 0, dp_recv_rdy = 0, send_val = 0, busy = 0, dp_stage = 0.
- Reset asserted mid-operation aborts immediately: the frame is discarded and nothing is emitted.
- IDLE:
  - recv_rdy = 1.
  - On recv fire: buffer <= recv frame; stage <= 0; go to ISSUE.
- ISSUE:
  - dp_send_val = 1; dp_send_* = buffer; dp_stage = stage.
  - On dp_send_rdy: go to WAIT.
- WAIT:
  - dp_recv_rdy = 1; dp_stage held.
  - On dp_recv_val: buffer <= dp_recv_*.
  - If stage == N_STAGES-1, go to DRAIN. Otherwise stage <= stage+1 and go to ISSUE.
- DRAIN:
  - send_val = 1; send_* = buffer.
  - On send_rdy: go to IDLE; stage <= 0.
- recv_rdy is 0 outside IDLE. There is no overlap: the next frame is accepted no earlier than the cycle after the DRAIN transfer.
- dp_recv_val outside WAIT is ignored (dp_recv_rdy = 0). A result arriving in the same cycle as the issue is not captured; the datapath must hold it.
- Minimum latency, recv fire to send_val high: 1 + 2*N_STAGES cycles (8-point: 7).
- dp_send_* and send_* always reflect the buffer. Only the val signals qualify them.
- SIZE_FFT = 2: N_STAGES = 1, so WAIT goes straight to DRAIN.

Optional Feature:
- Macro: FFT_STAGE_SEQUENCER_BITREV_EN.
- Defined: on the IDLE load, buffer[bitrev(i)] <= recv[i], using N_STAGES-bit reversal. The Cooley-Tukey input permutation is then done inside the sequencer.
- Undefined: buffer[i] <= recv[i]; the upstream block supplies bit-reversed order.
- Datapath-side and output-side behaviour are identical in both builds.

Test Plan (SIZE_FFT=8, BIT_WIDTH=32; stub datapath returns real+stage+1, imaginary unchanged, ready always, result one cycle after accept):
- Reset, then idle 5 cycles -> recv_rdy=1, busy=0, all vals 0, dp_stage=0.
- Frame real=0..7, imaginary=0; send_rdy=1 -> dp_stage sequence 0,1,2; send_val 7 cycles after recv fire; send_real = i+6 (bitrev build: bitrev(i)+6).
- Hold send_rdy=0 for 10 cycles in DRAIN -> send_val stays 1, data stable, recv_rdy=0; release -> IDLE next cycle, recv_rdy=1.
- Stub delays dp_send_rdy 3 cycles and dp_recv_val 4 cycles per stage -> dp_stage stable while waiting; output identical to the previous test.
- Assert reset during stage-1 WAIT -> immediately recv_rdy=1, busy=0, dp_stage=0; a new frame completes correctly with no stale data.
- recv_val held high across two back-to-back frames -> second frame accepted only in IDLE after the first DRAIN transfer; both outputs correct.

Source files
------------

// File: rtl/fft_cooley_tukey_stage_sequencer_if.sv
// rtl/fft_cooley_tukey_stage_sequencer_if.sv - frame-wide valid/ready channel
//
// Purpose: carries one complete FFT frame (SIZE_FFT complex words) plus a
// valid/ready handshake. A transfer happens on a cycle with val && rdy.
//
// Signals:
//   frame_real       SIZE_FFT x BIT_WIDTH  real parts, index 0 = point 0
//   frame_imaginary  SIZE_FFT x BIT_WIDTH  imaginary parts
//   val              producer has a frame
//   rdy              consumer accepts the frame
// Modports: master = producer (drives data/val), slave = consumer (drives rdy).
interface fft_cooley_tukey_stage_sequencer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int SIZE_FFT  = 8
);
  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] frame_real;
  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] frame_imaginary;
  logic                               val;
  logic                               rdy;

  modport master (output frame_real, output frame_imaginary, output val, input rdy);
  modport slave  (input frame_real, input frame_imaginary, input val, output rdy);
endinterface

// File: rtl/fft_cooley_tukey_stage_sequencer.sv
// rtl/fft_cooley_tukey_stage_sequencer.sv - folded Cooley-Tukey FFT stage sequencer
//
// Purpose: accepts a full frame, holds it in an internal buffer and runs it
// through one external stage datapath N_STAGES times (stage 0 first), then
// emits the finished frame downstream. One frame in flight at a time.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-high reset; aborts any frame in flight
//   recv      slave   input frame from the deserializer
//   dp_send   master  buffer contents to the stage datapath
//   dp_stage  out     stage index configuring crossbars/twiddles
//   dp_recv   slave   stage result from the datapath
//   send      master  finished frame to the serializer
//   busy      out     high whenever a frame is being processed
//
// Build option: FFT_STAGE_SEQUENCER_BITREV_EN - when defined, the input
// bit-reversal permutation is applied while loading the buffer; otherwise the
// upstream block must already deliver bit-reversed order.
module fft_cooley_tukey_stage_sequencer #(
  parameter  int BIT_WIDTH = 32,
  parameter  int SIZE_FFT  = 8,
  localparam int N_STAGES  = $clog2(SIZE_FFT),
  localparam int STAGE_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  fft_cooley_tukey_stage_sequencer_if.slave    recv,
  fft_cooley_tukey_stage_sequencer_if.master   dp_send,
  output logic [STAGE_W-1:0]                   dp_stage,
  fft_cooley_tukey_stage_sequencer_if.slave    dp_recv,
  fft_cooley_tukey_stage_sequencer_if.master   send,
  output logic                                 busy
);

  typedef logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] frame_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

  state_t               state;
  logic [STAGE_W-1:0]   stage;
  frame_t               buf_real;
  frame_t               buf_imaginary;
  frame_t               load_real;
  frame_t               load_imaginary;

`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
  function automatic logic [N_STAGES-1:0] bitrev(input logic [N_STAGES-1:0] idx);
    logic [N_STAGES-1:0] r;
    for (int b = 0; b < N_STAGES; b++) begin
      r[b] = idx[N_STAGES-1-b];
    end
    return r;
  endfunction
`endif

  // Input load path: optionally scatters point i to slot bitrev(i) so the
  // stages see Cooley-Tukey decimation-in-time order.
  always_comb begin
    load_real      = '0;
    load_imaginary = '0;
    for (int i = 0; i < SIZE_FFT; i++) begin
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
      load_real[bitrev(N_STAGES'(i))]      = recv.frame_real[i];
      load_imaginary[bitrev(N_STAGES'(i))] = recv.frame_imaginary[i];
`else
      load_real[i]      = recv.frame_real[i];
      load_imaginary[i] = recv.frame_imaginary[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      stage         <= '0;
      buf_real      <= '0;
      buf_imaginary <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // recv.rdy is high throughout IDLE, so val alone means a transfer.
          if (recv.val) begin
            buf_real      <= load_real;
            buf_imaginary <= load_imaginary;
            stage         <= '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dp_send.rdy) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dp_recv.val) begin
            buf_real      <= dp_recv.frame_real;
            buf_imaginary <= dp_recv.frame_imaginary;
            if (stage == LAST_STAGE) begin
              state <= S_DRAIN;
            end else begin
              stage <= stage + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (send.rdy) begin
            stage <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs depend on state only; data buses always show the buffer.
  assign recv.rdy                = (state == S_IDLE);
  assign dp_send.val             = (state == S_ISSUE);
  assign dp_recv.rdy             = (state == S_WAIT);
  assign send.val                = (state == S_DRAIN);
  assign busy                    = (state != S_IDLE);
  assign dp_stage                = stage;
  assign dp_send.frame_real      = buf_real;
  assign dp_send.frame_imaginary = buf_imaginary;
  assign send.frame_real         = buf_real;
  assign send.frame_imaginary    = buf_imaginary;

endmodule

// File: tb/tb_fft_cooley_tukey_stage_sequencer.sv
// tb/tb_fft_cooley_tukey_stage_sequencer.sv - self-checking bench for the stage sequencer
module tb_fft_cooley_tukey_stage_sequencer;
  localparam int BW = 32;
  localparam int N  = 8;
  localparam int NS = 3;

  typedef logic [N-1:0][BW-1:0] frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dp_stage;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // stub datapath configuration and observations
  int         send_delay = 0;
  int         recv_delay = 0;
  logic [1:0] stage_log[$];
  bit         stage_unstable = 0;

  always #5 clk = ~clk;

  fft_cooley_tukey_stage_sequencer_if #(.BIT_WIDTH(BW), .SIZE_FFT(N)) recv_if ();
  fft_cooley_tukey_stage_sequencer_if #(.BIT_WIDTH(BW), .SIZE_FFT(N)) dp_send_if ();
  fft_cooley_tukey_stage_sequencer_if #(.BIT_WIDTH(BW), .SIZE_FFT(N)) dp_recv_if ();
  fft_cooley_tukey_stage_sequencer_if #(.BIT_WIDTH(BW), .SIZE_FFT(N)) send_if ();

  fft_cooley_tukey_stage_sequencer #(.BIT_WIDTH(BW), .SIZE_FFT(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv     (recv_if.slave),
    .dp_send  (dp_send_if.master),
    .dp_stage (dp_stage),
    .dp_recv  (dp_recv_if.slave),
    .send     (send_if.master),
    .busy     (busy)
  );

  // Reference: load permutation, then each stage s adds s+1 to every real word.
  function automatic int rev3(input int x);
    return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
  endfunction

  function automatic void model(input frame_t r, input frame_t im,
                                output frame_t out_r, output frame_t out_i);
    for (int i = 0; i < N; i++) begin
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
      out_r[i] = r[rev3(i)];
      out_i[i] = im[rev3(i)];
`else
      out_r[i] = r[i];
      out_i[i] = im[i];
`endif
    end
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < N; i++)
        out_r[i] = out_r[i] + 32'(s + 1);
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = $urandom;
    return f;
  endfunction

  // Stub stage datapath: accepts after send_delay cycles, answers
  // recv_delay cycles after the accept, holding the result until taken.
  initial begin
    bit         sf, rf, have_res, holding;
    int         acc_cnt, res_cnt;
    frame_t     op_r, op_i;
    logic [1:0] op_s, hold_stage;
    sf = 0; rf = 0; have_res = 0; holding = 0; acc_cnt = 0; res_cnt = 0;
    op_r = '0; op_i = '0; op_s = '0; hold_stage = '0;
    dp_send_if.rdy = 1'b0;
    dp_recv_if.val = 1'b0;
    dp_recv_if.frame_real = '0;
    dp_recv_if.frame_imaginary = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sf = 0; rf = 0; have_res = 0; holding = 0; acc_cnt = 0; res_cnt = 0;
        dp_send_if.rdy = 1'b0;
        dp_recv_if.val = 1'b0;
        continue;
      end
      if (sf) begin
        for (int i = 0; i < N; i++) begin
          dp_recv_if.frame_real[i] = op_r[i] + 32'(op_s) + 32'd1;
          dp_recv_if.frame_imaginary[i] = op_i[i];
        end
        stage_log.push_back(op_s);
        have_res = 1; res_cnt = 0; acc_cnt = 0;
      end
      if (rf) begin
        have_res = 0; holding = 0;
        dp_recv_if.val = 1'b0;
      end
      if (dp_send_if.val && !have_res) begin
        if (acc_cnt >= send_delay) dp_send_if.rdy = 1'b1;
        else begin acc_cnt++; dp_send_if.rdy = 1'b0; end
      end else begin
        dp_send_if.rdy = 1'b0;
      end
      if (have_res) begin
        if (res_cnt >= recv_delay) dp_recv_if.val = 1'b1;
        else res_cnt++;
      end
      if (dp_send_if.val || dp_recv_if.rdy) begin
        if (!holding) begin holding = 1; hold_stage = dp_stage; end
        else if (dp_stage !== hold_stage) stage_unstable = 1;
      end
      sf = dp_send_if.val && dp_send_if.rdy;
      if (sf) begin
        op_r = dp_send_if.frame_real;
        op_i = dp_send_if.frame_imaginary;
        op_s = dp_stage;
      end
      rf = dp_recv_if.val && dp_recv_if.rdy;
    end
  end

  // Presents a frame, waits for acceptance, then for send_val. Returns at
  // the negedge where send_val is first seen; lat counts cycles from the fire.
  task automatic run_frame(input frame_t r, input frame_t im, output int lat,
                           output frame_t out_r, output frame_t out_i, output bit timeout);
    int k;
    timeout = 0; lat = 0; out_r = '0; out_i = '0;
    recv_if.frame_real = r;
    recv_if.frame_imaginary = im;
    recv_if.val = 1'b1;
    k = 0;
    while (!recv_if.rdy && k < 200) begin @(negedge clk); k++; end
    if (!recv_if.rdy) begin timeout = 1; recv_if.val = 1'b0; return; end
    @(negedge clk);
    recv_if.val = 1'b0;
    lat = 1;
    while (!send_if.val && lat < 500) begin @(negedge clk); lat++; end
    if (!send_if.val) begin timeout = 1; return; end
    out_r = send_if.frame_real;
    out_i = send_if.frame_imaginary;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    recv_if.val = 1'b0;
    recv_if.frame_real = '0;
    recv_if.frame_imaginary = '0;
    send_if.rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (recv_if.rdy !== 1'b1) begin bad++; $display("FAIL reset_recv_rdy got=%b exp=1", recv_if.rdy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({dp_send_if.val, dp_recv_if.rdy, send_if.val} !== 3'b000) begin
      bad++; $display("FAIL reset_vals got=%b exp=000", {dp_send_if.val, dp_recv_if.rdy, send_if.val}); end
    total++; if (dp_stage !== 2'd0) begin bad++; $display("FAIL reset_dp_stage got=%0d exp=0", dp_stage); end
    total++; if (send_if.frame_real !== '0) begin bad++; $display("FAIL reset_buffer got=%h exp=0", send_if.frame_real); end
  endtask

  task automatic test_basic();
    frame_t r, im, er, ei, gr, gi;
    int lat; bit to;
    for (int i = 0; i < N; i++) begin r[i] = 32'(i); im[i] = '0; end
    model(r, im, er, ei);
    stage_log.delete();
    send_if.rdy = 1'b1;
    run_frame(r, im, lat, gr, gi, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++; if (lat !== 7) begin bad++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    total++; if (gr !== er) begin bad++; $display("FAIL basic_real got=%h exp=%h", gr, er); end
    total++; if (gi !== ei) begin bad++; $display("FAIL basic_imag got=%h exp=%h", gi, ei); end
    total++; if (stage_log.size() !== NS) begin bad++; $display("FAIL basic_stage_count got=%0d exp=%0d", stage_log.size(), NS); end
    else for (int s = 0; s < NS; s++) begin
      total++; if (stage_log[s] !== 2'(s)) begin bad++; $display("FAIL basic_stage_seq idx=%0d got=%0d exp=%0d", s, stage_log[s], s); end
    end
    @(negedge clk);
    total++; if (recv_if.rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_back_idle got rdy=%b busy=%b exp rdy=1 busy=0", recv_if.rdy, busy); end
  endtask

  task automatic test_random();
    frame_t r, im, er, ei, gr, gi;
    int lat; bit to;
    send_if.rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send_delay = $urandom_range(0, 3);
      recv_delay = $urandom_range(0, 3);
      r = rand_frame(); im = rand_frame();
      model(r, im, er, ei);
      run_frame(r, im, lat, gr, gi, to);
      total++; if (to || lat !== 1 + NS * (2 + send_delay + recv_delay)) begin
        bad++; $display("FAIL random_latency n=%0d got=%0d exp=%0d", n, lat, 1 + NS * (2 + send_delay + recv_delay)); end
      total++; if (gr !== er || gi !== ei) begin
        bad++; $display("FAIL random_data n=%0d got=%h/%h exp=%h/%h", n, gr, gi, er, ei); end
      @(negedge clk);
    end
    send_delay = 0; recv_delay = 0;
  endtask

  task automatic test_backpressure();
    frame_t r, im, er, ei, gr, gi;
    int lat; bit to;
    r = rand_frame(); im = rand_frame();
    model(r, im, er, ei);
    send_if.rdy = 1'b0;
    run_frame(r, im, lat, gr, gi, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (send_if.val !== 1'b1 || recv_if.rdy !== 1'b0 || send_if.frame_real !== er || send_if.frame_imaginary !== ei) begin
        bad++; $display("FAIL bp_hold c=%0d got val=%b rdy=%b real=%h exp val=1 rdy=0 real=%h", c, send_if.val, recv_if.rdy, send_if.frame_real, er); end
    end
    send_if.rdy = 1'b1;
    @(negedge clk);
    total++; if (recv_if.rdy !== 1'b1 || send_if.val !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b val=%b busy=%b exp 1 0 0", recv_if.rdy, send_if.val, busy); end
  endtask

  task automatic test_delays();
    frame_t r, im, er, ei, gr, gi;
    int lat; bit to;
    for (int i = 0; i < N; i++) begin r[i] = 32'(i); im[i] = '0; end
    model(r, im, er, ei);
    send_delay = 3; recv_delay = 4;
    stage_unstable = 0;
    stage_log.delete();
    send_if.rdy = 1'b1;
    run_frame(r, im, lat, gr, gi, to);
    total++; if (to || lat !== 28) begin bad++; $display("FAIL delay_latency got=%0d exp=28", lat); end
    total++; if (gr !== er || gi !== ei) begin bad++; $display("FAIL delay_data got=%h exp=%h", gr, er); end
    total++; if (stage_unstable !== 1'b0) begin bad++; $display("FAIL delay_stage_stable got=%b exp=0", stage_unstable); end
    total++; if (stage_log.size() !== NS || stage_log[NS-1] !== 2'(NS-1)) begin
      bad++; $display("FAIL delay_stage_seq got size=%0d exp=%0d", stage_log.size(), NS); end
    @(negedge clk);
    send_delay = 0; recv_delay = 0;
  endtask

  task automatic test_reset_mid();
    frame_t r, im, er, ei, gr, gi;
    int lat, k; bit to;
    recv_delay = 4;
    send_if.rdy = 1'b1;
    r = rand_frame(); im = rand_frame();
    recv_if.frame_real = r; recv_if.frame_imaginary = im; recv_if.val = 1'b1;
    @(negedge clk);
    recv_if.val = 1'b0;
    k = 0;
    while (!(dp_recv_if.rdy && dp_stage == 2'd1) && k < 200) begin @(negedge clk); k++; end
    total++; if (!(dp_recv_if.rdy && dp_stage == 2'd1)) begin bad++; $display("FAIL mid_reach_wait1 got stage=%0d exp=1", dp_stage); end
    reset = 1'b1;
    #1;
    total++; if (recv_if.rdy !== 1'b1 || busy !== 1'b0 || dp_stage !== 2'd0) begin
      bad++; $display("FAIL mid_reset_state got rdy=%b busy=%b stage=%0d exp 1 0 0", recv_if.rdy, busy, dp_stage); end
    total++; if (send_if.val !== 1'b0 || dp_send_if.val !== 1'b0 || send_if.frame_real !== '0) begin
      bad++; $display("FAIL mid_reset_outputs got sval=%b dval=%b real=%h exp 0 0 0", send_if.val, dp_send_if.val, send_if.frame_real); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    recv_delay = 0;
    r = rand_frame(); im = rand_frame();
    model(r, im, er, ei);
    run_frame(r, im, lat, gr, gi, to);
    total++; if (to || lat !== 7) begin bad++; $display("FAIL mid_new_latency got=%0d exp=7", lat); end
    total++; if (gr !== er || gi !== ei) begin bad++; $display("FAIL mid_new_data got=%h exp=%h", gr, er); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame_t ra, ia, rb, ib, era, eia, erb, eib;
    frame_t outs_r[$], outs_i[$];
    int fires;
    bit f, o;
    ra = rand_frame(); ia = rand_frame(); rb = rand_frame(); ib = rand_frame();
    model(ra, ia, era, eia);
    model(rb, ib, erb, eib);
    send_if.rdy = 1'b1;
    fires = 0;
    recv_if.frame_real = ra; recv_if.frame_imaginary = ia; recv_if.val = 1'b1;
    for (int c = 0; c < 300 && outs_r.size() < 2; c++) begin
      f = recv_if.val && recv_if.rdy;
      o = send_if.val && send_if.rdy;
      if (o) begin
        outs_r.push_back(send_if.frame_real);
        outs_i.push_back(send_if.frame_imaginary);
        total++; if (recv_if.rdy !== 1'b0) begin bad++; $display("FAIL b2b_overlap got rdy=%b exp=0", recv_if.rdy); end
      end
      if (f) begin
        fires++;
        if (fires == 2) begin
          total++; if (outs_r.size() !== 1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_second_accept got outs=%0d busy=%b exp outs=1 busy=0", outs_r.size(), busy); end
        end
      end
      @(negedge clk);
      if (f) begin
        if (fires == 1) begin recv_if.frame_real = rb; recv_if.frame_imaginary = ib; end
        else recv_if.val = 1'b0;
      end
    end
    recv_if.val = 1'b0;
    total++; if (fires !== 2 || outs_r.size() !== 2) begin
      bad++; $display("FAIL b2b_counts got fires=%0d outs=%0d exp 2 2", fires, outs_r.size()); end
    else begin
      total++; if (outs_r[0] !== era || outs_i[0] !== eia) begin bad++; $display("FAIL b2b_first got=%h exp=%h", outs_r[0], era); end
      total++; if (outs_r[1] !== erb || outs_i[1] !== eib) begin bad++; $display("FAIL b2b_second got=%h exp=%h", outs_r[1], erb); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_delays();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
